sram_sp_4096x16: RTL and testbench
==================================

// Module: sram_sp_4096x16
// PURPOSE
// - Single-port synchronous SRAM, 4096 words x 16 bits, one access per clock (read or write).
// - Behavioural equivalent of the SHAB90 4096x16 macro; the instance name in the design is SHAB90_4096X16X1CM16.
// - Used by the CORE buffer as scratch storage: bursts are written, then read back in order.
// PARAMETERS
// - ADDR_W  12     address width
// - DATA_W  16     word width
// - DEPTH   4096   number of words; must equal 2**ADDR_W
// PORTS
// - clk    in   1        clock; all activity on the rising edge (replaces macro pin CK)
// - rst_n  in   1        reset, synchronous, active-low
// - A      in   ADDR_W   word address, sampled at posedge clk
// - DI     in   DATA_W   write data, sampled at posedge clk
// - DO     out  DATA_W   read data, registered
// - WEB    in   1        write enable, active-low: 0 = write, 1 = read
// - OE     in   1        output enable, active-high
// - CS     in   1        chip select, active-high
// BEHAVIOUR
// - Reset:
//   - At posedge clk with rst_n=0, the DO register clears to 0.
//   - Array contents are not cleared. No access occurs that cycle, even if CS=1.
// - Idle:
//   - At posedge with CS=0, no read or write occurs. The DO register holds its value.
// - Write:
//   - At posedge with CS=1 and WEB=0: mem[A] <= DI.
//   - Write-through: the DO register <= DI in the same edge.
// - Read:
//   - At posedge with CS=1 and WEB=1: the DO register <= mem[A].
//   - Latency is 1 cycle: the address presented before edge N gives data on DO after edge N.
// - Back-to-back accesses:
//   - Any mix of reads and writes is allowed on consecutive cycles.
//   - A read of an address written on the previous edge returns the new data.
// - Output enable:
//   - DO = OE ? DO register : 0. OE is combinational, with no tristate.
//   - OE does not gate reads or writes.
// - Uninitialised words:
//   - A read before any write returns X in simulation.
//   - X is acceptable; the bench must not check it.
// - Address width and range:
//   - A is exactly ADDR_W bits, so every address is in range and there is no wrap logic.
//   - Address 4095 behaves like any other address.
// - Reset mid-operation:
//   - An access presented on the same edge as rst_n=0 is dropped; memory keeps its old value.
//   - Accesses resume on the first edge with rst_n=1.
// - Other:
//   - No combinational path from A, DI or WEB to DO; only OE affects DO combinationally.
//   - X on A or WEB with CS=1 during a write corrupts nothing except mem at a known A.
// TESTING
// - Reset then read:
//   - rst_n=0 for 2 cycles, OE=1 -> DO=0x0000.
// - Write then read:
//   - Write 0x1234@0, 0xABCD@1, 0xFFFF@4095 on consecutive cycles.
//   - Then read 0, 1, 4095 -> DO=0x1234, 0xABCD, 0xFFFF, each 1 cycle after its address.
// - Write-through and read-after-write:
//   - Write 0x5A5A@7 -> DO=0x5A5A after that edge.
//   - A read of 7 on the next cycle -> 0x5A5A.
// - CS and OE gating:
//   - CS=0, WEB=0, DI=0x0000, A=0 -> mem[0] still 0x1234; DO holds its prior value.
//   - OE=0 -> DO=0; OE=1 again -> the held value reappears.
// - Reset mid-burst:
//   - Write 0x1111@2 with rst_n=0 on that edge -> DO=0 and mem[2] unchanged.
//   - A later read of 2 shows its previous contents.
// - Burst pattern:
//   - Write addr k with data k^0xA5A5 for k=0..3 (WEB=0), then read back k=0..3 (WEB=1).
//   - Each DO matches, in order, with 1-cycle latency.

Source files
------------

// File: rtl/sram_sp_4096x16_if.sv
// -----------------------------------------------------------------------------
// sram_sp_4096x16_if
// Bus bundle for the single-port 4096x16 scratch SRAM.
//
// Signals (names follow the macro pin names):
//   A    address, driven by master
//   DI   write data, driven by master
//   WEB  write enable, active-low (0 = write, 1 = read), driven by master
//   OE   output enable, active-high, driven by master
//   CS   chip select, active-high, driven by master
//   DO   read data, driven by slave (the SRAM)
//
// Protocol: there is no valid/ready backpressure. Every rising clk edge with
// CS=1 is exactly one access, and it is always accepted. A read returns its
// data on DO after that same edge, so the latency is one cycle. OE only masks
// DO combinationally and never affects accesses.
// -----------------------------------------------------------------------------
interface sram_sp_4096x16_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] DI;
  logic [DATA_W-1:0] DO;
  logic              WEB;
  logic              OE;
  logic              CS;

  modport master (
    output A,
    output DI,
    output WEB,
    output OE,
    output CS,
    input  DO
  );

  modport slave (
    input  A,
    input  DI,
    input  WEB,
    input  OE,
    input  CS,
    output DO
  );
endinterface

// File: rtl/sram_sp_4096x16.sv
// -----------------------------------------------------------------------------
// sram_sp_4096x16
// Behavioural single-port synchronous SRAM, 4096 words x 16 bits. It stands in
// for the SHAB90 4096x16 macro, and the storage block carries the macro instance
// name SHAB90_4096X16X1CM16. The CORE buffer uses it as scratch storage: bursts
// are written, then read back in order.
//
// Ports:
//   clk    clock; all activity happens on the rising edge (macro pin CK)
//   rst_n  synchronous, active-low reset; clears the DO register only
//   bus    slave side of sram_sp_4096x16_if (A, DI, WEB, OE, CS in; DO out)
//
// Behaviour at each rising edge:
//   rst_n=0              DO register <= 0. No access occurs, even with CS=1.
//   CS=0                 idle. The DO register holds its value.
//   CS=1, WEB=0          mem[A] <= DI, and DO register <= DI (write-through)
//   CS=1, WEB=1          DO register <= mem[A]
// DO = OE ? DO register : 0. The only combinational path to DO is from OE.
// -----------------------------------------------------------------------------
module sram_sp_4096x16 #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_sp_4096x16_if.slave      bus
);

  // A is exactly ADDR_W bits wide, so every address is in range only if the
  // array covers the full address space.
  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("sram_sp_4096x16: DEPTH must equal 2**ADDR_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] do_q;

  // Reset only gates the access. It does not clear the array, because the
  // macro has no array reset.
  logic access_en;
  logic wr_en;
  logic rd_en;

  assign access_en = rst_n & bus.CS;
  assign wr_en     = access_en & ~bus.WEB;
  assign rd_en     = access_en &  bus.WEB;

  // Storage array. This block is named after the macro instance so that
  // hierarchical references from the CORE buffer stay valid.
  always_ff @(posedge clk) begin : SHAB90_4096X16X1CM16
    if (wr_en) begin
      mem[bus.A] <= bus.DI;
    end
  end

  // Output register. A write copies DI straight into it. A read fetches the
  // array word. A read of a word written on the previous edge sees the new
  // value, because that write has already landed in mem.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      do_q <= '0;
    end else if (wr_en) begin
      do_q <= bus.DI;
    end else if (rd_en) begin
      do_q <= mem[bus.A];
    end
  end

  // OE masks DO combinationally. The output is never tristated.
  assign bus.DO = bus.OE ? do_q : '0;

endmodule

// File: tb/tb_sram_sp_4096x16.sv
// -----------------------------------------------------------------------------
// tb_sram_sp_4096x16
// Self-checking bench for sram_sp_4096x16. Driver tasks apply one access per
// clock. After each edge they push the expected DO, computed by a reference
// model built on an associative array, onto exp_q. A monitor on the falling
// edge pops that entry and compares it with DO. Words never written are unknown
// and are not checked.
// -----------------------------------------------------------------------------
module tb_sram_sp_4096x16;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  // clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_sp_4096x16_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_sp_4096x16 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4096)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // reference model: known array words plus the output register
  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] ref_do;
  logic              ref_do_known;

  // scoreboard: bit DATA_W = "check this entry", low bits = expected DO
  logic [DATA_W:0] exp_q [$];
  string           name_q [$];
  int              checks;
  int              errors;

  initial begin
    checks       = 0;
    errors       = 0;
    ref_do       = '0;
    ref_do_known = 1'b0;
  end

  // driver: one clock of stimulus, then record the expected DO for that edge
  task automatic access(input logic rst_v, input logic cs, input logic web,
                        input logic oe, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] di, input string name);
    logic [DATA_W:0] item;
    rst_n   = rst_v;
    bus.CS  = cs;
    bus.WEB = web;
    bus.OE  = oe;
    bus.A   = a;
    bus.DI  = di;
    @(posedge clk);
    // reference behaviour for this edge
    if (!rst_v) begin
      ref_do       = '0;
      ref_do_known = 1'b1;
    end else if (cs) begin
      if (!web) begin
        ref_mem[int'(a)] = di;
        ref_do           = di;
        ref_do_known     = 1'b1;
      end else if (ref_mem.exists(int'(a))) begin
        ref_do       = ref_mem[int'(a)];
        ref_do_known = 1'b1;
      end else begin
        ref_do_known = 1'b0;
      end
    end
    item[DATA_W]     = !oe || ref_do_known;
    item[DATA_W-1:0] = oe ? ref_do : '0;
    exp_q.push_back(item);
    name_q.push_back(name);
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] di,
                    input string name);
    access(1'b1, 1'b1, 1'b0, 1'b1, a, di, name);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input string name);
    access(1'b1, 1'b1, 1'b1, 1'b1, a, $urandom_range(0, 16'hFFFF), name);
  endtask

  // monitor: compares DO on the falling edge against the oldest entry
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [DATA_W:0] item;
      string           nm;
      item = exp_q.pop_front();
      nm   = name_q.pop_front();
      if (item[DATA_W]) begin
        checks++;
        if (bus.DO !== item[DATA_W-1:0]) begin
          errors++;
          $display("FAIL %s: DO=%h expected %h at %0t", nm, bus.DO,
                   item[DATA_W-1:0], $time);
        end
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    rst_n   = 1'b0;
    bus.CS  = 1'b0;
    bus.WEB = 1'b1;
    bus.OE  = 1'b1;
    bus.A   = '0;
    bus.DI  = '0;
    @(negedge clk);
    #1;

    // reset with a random access presented: DO must read 0
    for (int i = 0; i < 2; i++) begin
      access(1'b0, 1'(i), 1'b0, 1'b1, 12'(i + 100), 16'hDEAD, "reset_do");
    end

    // write then read, including the top address
    wr(12'd0,    16'h1234, "wr_thru_0");
    wr(12'd1,    16'hABCD, "wr_thru_1");
    wr(12'd4095, 16'hFFFF, "wr_thru_4095");
    rd(12'd0,    "rd_0");
    rd(12'd1,    "rd_1");
    rd(12'd4095, "rd_4095");

    // write-through and read-after-write
    wr(12'd7, 16'h5A5A, "wr_thru_7");
    rd(12'd7, "raw_7");

    // CS and OE gating
    access(1'b1, 1'b0, 1'b0, 1'b1, 12'd0, 16'h0000, "cs0_hold");
    access(1'b1, 1'b0, 1'b1, 1'b0, 12'd3, 16'h0000, "oe0_zero");
    access(1'b1, 1'b0, 1'b1, 1'b1, 12'd3, 16'h0000, "oe1_restore");
    rd(12'd0, "cs0_no_write_0");
    access(1'b1, 1'b1, 1'b1, 1'b0, 12'd1, 16'h0000, "oe0_read");
    access(1'b1, 1'b0, 1'b1, 1'b1, 12'd1, 16'h0000, "oe1_after_read");

    // reset mid-burst drops the write
    wr(12'd2, 16'h2222, "wr_2");
    access(1'b0, 1'b1, 1'b0, 1'b1, 12'd2, 16'h1111, "rst_drop_wr");
    rd(12'd2, "rd_2_after_rst");

    // burst pattern
    for (int k = 0; k < 4; k++) begin
      wr(12'(k), 16'(k) ^ 16'hA5A5, "burst_wr");
    end
    for (int k = 0; k < 4; k++) begin
      rd(12'(k), "burst_rd");
    end

    // random mix; addresses are biased toward a small pool to hit written words
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              r, c, w, o;
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                      : 12'($urandom_range(4088, 4095) + $urandom_range(0, 1) * 8);
      d = 16'($urandom_range(0, 16'hFFFF));
      r = ($urandom_range(0, 19) != 0);
      c = ($urandom_range(0, 4) != 0);
      w = ($urandom_range(0, 1) != 0);
      o = ($urandom_range(0, 7) != 0);
      access(r, c, w, o, a, d, "random");
    end

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
